// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the RAM port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;
  localparam int LAT_W = 4;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: LS-priority winner select with an IF starvation counter.
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic ls_req,
  input  logic arb_en,
  output logic win_id,
  output logic win_vld
);
  import mem_arb_pkg::*;
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  logic [SW-1:0] starve_q, starve_d;
  logic sat, force_if;
  always_comb begin
    sat      = starve_q == SW'(STARVE_LIMIT);
    force_if = sat && (STARVE_LIMIT != 0);
    win_vld  = arb_en && (if_req || ls_req);
    win_id   = (ls_req && !(if_req && force_if)) ? REQ_LS : REQ_IF;
    starve_d = !if_req ? '0 :
               !win_vld ? starve_q :
               (win_id == REQ_IF) ? '0 :
               sat ? starve_q : starve_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch and load/store.
// Define MEM_ARB_PERF_EN to build the grant/stall performance counters.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iIF_REQ,
  input  logic [ADDR_W-1:0] iIF_ADDR,
  output logic              oIF_GNT,
  output logic              oIF_VALID,
  output logic [DATA_W-1:0] oIF_DATA,
  input  logic              iLS_REQ,
  input  logic              iLS_WR,
  input  logic [ADDR_W-1:0] iLS_ADDR,
  input  logic [DATA_W-1:0] iLS_WDATA,
  output logic              oLS_GNT,
  output logic              oLS_VALID,
  output logic [DATA_W-1:0] oLS_RDATA,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic [DATA_W-1:0] oRAM_WDATA,
  input  logic [DATA_W-1:0] iRAM_DATA,
  output logic [31:0]       oPERF_IF_CNT,
  output logic [31:0]       oPERF_LS_CNT,
  output logic [31:0]       oPERF_STALL_CNT
);
  import mem_arb_pkg::*;
  state_e state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic id_q, id_d, win_id, win_vld;
  logic if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d, if_valid_q, if_valid_d, ls_valid_q, ls_valid_d;
  logic ram_ce_q, ram_ce_d, ram_rd_q, ram_rd_d, ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d, if_data_q, if_data_d, ls_rdata_q, ls_rdata_d, rdata;

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk(iCLK), .rst_n(iRST_n), .if_req(iIF_REQ), .ls_req(iLS_REQ),
    .arb_en(state_q != ACCESS), .win_id(win_id), .win_vld(win_vld)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    ls_valid_d  = 1'b0;
    if_data_d   = if_data_q;
    ls_rdata_d  = ls_rdata_q;
    ram_ce_d    = ram_ce_q;
    ram_rd_d    = ram_rd_q;
    ram_wr_d    = ram_wr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata       = ram_wr_q ? '0 : iRAM_DATA;
    if (state_q == ACCESS) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d     = RESP;
        cnt_d       = '0;
        ram_ce_d    = 1'b0;
        ram_rd_d    = 1'b0;
        ram_wr_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        if_valid_d  = id_q == REQ_IF;
        ls_valid_d  = id_q == REQ_LS;
        if_data_d   = if_valid_d ? rdata : if_data_q;
        ls_rdata_d  = ls_valid_d ? rdata : ls_rdata_q;
      end
    end else if (win_vld) begin
      state_d     = ACCESS;
      cnt_d       = LAT_W'(RAM_LATENCY - 1);
      id_d        = win_id;
      if_gnt_d    = win_id == REQ_IF;
      ls_gnt_d    = win_id == REQ_LS;
      ram_ce_d    = 1'b1;
      ram_wr_d    = ls_gnt_d && iLS_WR;
      ram_rd_d    = !ram_wr_d;
      ram_addr_d  = ls_gnt_d ? iLS_ADDR : iIF_ADDR;
      ram_wdata_d = ls_gnt_d ? iLS_WDATA : '0;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      id_q        <= REQ_IF;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      ls_valid_q  <= 1'b0;
      if_data_q   <= '0;
      ls_rdata_q  <= '0;
      ram_ce_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_valid_q  <= if_valid_d;
      ls_valid_q  <= ls_valid_d;
      if_data_q   <= if_data_d;
      ls_rdata_q  <= ls_rdata_d;
      ram_ce_q    <= ram_ce_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end

  assign oIF_GNT    = if_gnt_q;
  assign oLS_GNT    = ls_gnt_q;
  assign oIF_VALID  = if_valid_q;
  assign oLS_VALID  = ls_valid_q;
  assign oIF_DATA   = if_data_q;
  assign oLS_RDATA  = ls_rdata_q;
  assign oRAM_CE    = ram_ce_q;
  assign oRAM_RD    = ram_rd_q;
  assign oRAM_WR    = ram_wr_q;
  assign oRAM_ADDR  = ram_addr_q;
  assign oRAM_WDATA = ram_wdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_if_d, perf_ls_q, perf_ls_d, perf_stall_q, perf_stall_d;
  // A stall is a cycle whose closing edge leaves a pending request ungranted.
  always_comb begin
    perf_if_d    = perf_if_q + 32'(if_gnt_d && !(&perf_if_q));
    perf_ls_d    = perf_ls_q + 32'(ls_gnt_d && !(&perf_ls_q));
    perf_stall_d = perf_stall_q + 32'((iIF_REQ || iLS_REQ) && !if_gnt_d && !ls_gnt_d && !(&perf_stall_q));
  end
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      perf_if_q    <= '0;
      perf_ls_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_if_q    <= perf_if_d;
      perf_ls_q    <= perf_ls_d;
      perf_stall_q <= perf_stall_d;
    end
  assign oPERF_IF_CNT    = perf_if_q;
  assign oPERF_LS_CNT    = perf_ls_q;
  assign oPERF_STALL_CNT = perf_stall_q;
`else
  assign oPERF_IF_CNT    = '0;
  assign oPERF_LS_CNT    = '0;
  assign oPERF_STALL_CNT = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench, one DUT at RAM_LATENCY=1 and one at 3.
module tb_mem_port_arbiter;
  localparam int LIM = 4;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic if_req = 0, ls_req = 0, ls_wr = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, ram_data = 0;
  logic if_gnt, if_valid, ls_gnt, ls_valid, ram_ce, ram_rd, ram_wr;
  logic [31:0] if_data, ls_rdata, ram_addr, ram_wdata, perf_if, perf_ls, perf_st;
  logic b_if_req = 0, b_ls_req = 0, b_ls_wr = 0;
  logic [31:0] b_if_addr = 0, b_ls_addr = 0, b_ls_wdata = 0, b_ram_data = 0;
  logic b_if_gnt, b_if_valid, b_ls_gnt, b_ls_valid, b_ram_ce, b_ram_rd, b_ram_wr;
  logic [31:0] b_if_data, b_ls_rdata, b_ram_addr, b_ram_wdata, b_perf_if, b_perf_ls, b_perf_st;
  logic [230:0] outs_a, outs_b;
  assign outs_a = {if_gnt, if_valid, ls_gnt, ls_valid, ram_ce, ram_rd, ram_wr, if_data, ls_rdata,
                   ram_addr, ram_wdata, perf_if, perf_ls, perf_st};
  assign outs_b = {b_if_gnt, b_if_valid, b_ls_gnt, b_ls_valid, b_ram_ce, b_ram_rd, b_ram_wr, b_if_data,
                   b_ls_rdata, b_ram_addr, b_ram_wdata, b_perf_if, b_perf_ls, b_perf_st};

  int n_chk = 0, n_fail = 0;
  logic [31:0] ram [logic [31:0]];
  logic [31:0] model [logic [31:0]];

  mem_port_arbiter #(.RAM_LATENCY(LAT_A), .STARVE_LIMIT(LIM)) u0 (
    .iCLK(clk), .iRST_n(rst_n), .iIF_REQ(if_req), .iIF_ADDR(if_addr), .oIF_GNT(if_gnt),
    .oIF_VALID(if_valid), .oIF_DATA(if_data), .iLS_REQ(ls_req), .iLS_WR(ls_wr), .iLS_ADDR(ls_addr),
    .iLS_WDATA(ls_wdata), .oLS_GNT(ls_gnt), .oLS_VALID(ls_valid), .oLS_RDATA(ls_rdata),
    .oRAM_CE(ram_ce), .oRAM_RD(ram_rd), .oRAM_WR(ram_wr), .oRAM_ADDR(ram_addr),
    .oRAM_WDATA(ram_wdata), .iRAM_DATA(ram_data), .oPERF_IF_CNT(perf_if), .oPERF_LS_CNT(perf_ls),
    .oPERF_STALL_CNT(perf_st));

  mem_port_arbiter #(.RAM_LATENCY(LAT_B), .STARVE_LIMIT(LIM)) u1 (
    .iCLK(clk), .iRST_n(rst_n), .iIF_REQ(b_if_req), .iIF_ADDR(b_if_addr), .oIF_GNT(b_if_gnt),
    .oIF_VALID(b_if_valid), .oIF_DATA(b_if_data), .iLS_REQ(b_ls_req), .iLS_WR(b_ls_wr),
    .iLS_ADDR(b_ls_addr), .iLS_WDATA(b_ls_wdata), .oLS_GNT(b_ls_gnt), .oLS_VALID(b_ls_valid),
    .oLS_RDATA(b_ls_rdata), .oRAM_CE(b_ram_ce), .oRAM_RD(b_ram_rd), .oRAM_WR(b_ram_wr),
    .oRAM_ADDR(b_ram_addr), .oRAM_WDATA(b_ram_wdata), .iRAM_DATA(b_ram_data),
    .oPERF_IF_CNT(b_perf_if), .oPERF_LS_CNT(b_perf_ls), .oPERF_STALL_CNT(b_perf_st));

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] ram_rd_f(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_word(a);
  endfunction
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model.exists(a) ? model[a] : init_word(a);
  endfunction

  // RAM models: read data is correct only in the last cycle of a held command, garbage otherwise.
  int ce_a = 0, ce_b = 0;
  always @(negedge clk) begin
    if (ram_ce) begin
      if (ram_wr) ram[ram_addr] = ram_wdata;
      ram_data = (ram_rd && ce_a == LAT_A - 1) ? ram_rd_f(ram_addr) : $urandom;
      ce_a = ce_a + 1;
    end else begin
      ce_a = 0;
      ram_data = $urandom;
    end
    if (b_ram_ce) begin
      if (b_ram_wr) ram[b_ram_addr] = b_ram_wdata;
      b_ram_data = (b_ram_rd && ce_b == LAT_B - 1) ? ram_rd_f(b_ram_addr) : $urandom;
      ce_b = ce_b + 1;
    end else begin
      ce_b = 0;
      b_ram_data = $urandom;
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ram[a] = d;
    model[a] = d;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (outs_a !== '0 || outs_b !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got a=%h b=%h want 0", i, outs_a, outs_b);
      end
    end
    @(negedge clk);
    ls_wr = 0; ls_addr = 32'h20; ls_req = 1;
    for (int i = 0; i < 20 && !ls_gnt; i++) @(negedge clk);
    ls_req = 0;
    n_chk++;
    if (ls_gnt !== 1'b1 || ram_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_gnt got gnt=%b ce=%b want 1 1", ls_gnt, ram_ce);
    end
    rst_n = 0;
    #1;
    n_chk++;
    if (outs_a !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear got %h want 0", outs_a);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if (outs_a !== '0) begin
        n_fail++;
        $display("FAIL reset_no_valid cyc=%0d got %h want 0", i, outs_a);
      end
    end
  endtask

  task automatic txn(input bit di, input bit dl, input logic [31:0] ia, input logic [31:0] la,
                     input bit lw, input logic [31:0] lwd);
    int gi = -1, gl = -1, vi = -1, vl = -1, cyc = 0;
    logic [31:0] ei, el;
    el = lw ? 32'h0 : model_rd(la);
    if (dl && lw) model[la] = lwd;
    ei = model_rd(ia);
    @(negedge clk);
    if_req = di; if_addr = ia; ls_req = dl; ls_wr = lw; ls_addr = la; ls_wdata = lwd;
    while (((di && vi < 0) || (dl && vl < 0)) && cyc < 40) begin
      @(negedge clk);
      n_chk++;
      if ((if_gnt && (!di || gi >= 0)) || (ls_gnt && (!dl || gl >= 0)) || (if_gnt && ls_gnt) ||
          (if_valid && !di) || (ls_valid && !dl)) begin
        n_fail++;
        $display("FAIL txn_spurious cyc=%0d got gnt=%b%b valid=%b%b", cyc, if_gnt, ls_gnt, if_valid, ls_valid);
      end
      if (if_gnt) begin
        gi = cyc; if_req = 0; n_chk++;
        if ({ram_ce, ram_rd, ram_wr, ram_addr} !== {3'b110, ia}) begin
          n_fail++;
          $display("FAIL if_cmd got ce/rd/wr=%b%b%b addr=%h want 110 %h", ram_ce, ram_rd, ram_wr, ram_addr, ia);
        end
      end
      if (ls_gnt) begin
        gl = cyc; ls_req = 0; n_chk++;
        if ({ram_ce, ram_rd, ram_wr, ram_addr} !== {1'b1, ~lw, lw, la}) begin
          n_fail++;
          $display("FAIL ls_cmd got ce/rd/wr=%b%b%b addr=%h want 1%b%b %h", ram_ce, ram_rd, ram_wr, ram_addr, ~lw, lw, la);
        end
        if (lw) begin
          n_chk++;
          if (ram_wdata !== lwd) begin
            n_fail++;
            $display("FAIL ls_wdata got %h want %h", ram_wdata, lwd);
          end
        end
      end
      if (if_valid) begin
        vi = cyc; n_chk++;
        if (if_data !== ei || vi != gi + LAT_A) begin
          n_fail++;
          $display("FAIL if_resp got data=%h cyc=%0d want %h cyc=%0d", if_data, vi, ei, gi + LAT_A);
        end
      end
      if (ls_valid) begin
        vl = cyc; n_chk++;
        if (ls_rdata !== el || vl != gl + LAT_A) begin
          n_fail++;
          $display("FAIL ls_resp got data=%h cyc=%0d want %h cyc=%0d", ls_rdata, vl, el, gl + LAT_A);
        end
      end
      cyc++;
    end
    n_chk++;
    if ((di && vi < 0) || (dl && vl < 0)) begin
      n_fail++;
      $display("FAIL txn_timeout got vi=%0d vl=%0d want responses", vi, vl);
    end
    n_chk++;
    if (di && dl ? (gl != 0 || gi != LAT_A + 1) : (di ? gi : gl) != 0) begin
      n_fail++;
      $display("FAIL txn_order got gi=%0d gl=%0d (di=%0b dl=%0b)", gi, gl, di, dl);
    end
    @(negedge clk);
    n_chk++;
    if ({if_valid, ls_valid, ram_ce, if_gnt, ls_gnt} !== 5'b0 || (di && if_data !== ei) || (dl && ls_rdata !== el)) begin
      n_fail++;
      $display("FAIL txn_after got v=%b%b ce=%b data=%h/%h want idle with held data %h/%h",
               if_valid, ls_valid, ram_ce, if_data, ls_rdata, ei, el);
    end
  endtask

  task automatic test_if_read();
    preload(32'h100, 32'hDEAD_BEEF);
    txn(1, 0, 32'h100, 32'h0, 0, 32'h0);
  endtask

  task automatic test_collision();
    txn(1, 1, 32'h104, 32'h40, 1, 32'h1122_3344);
    txn(0, 1, 32'h0, 32'h40, 0, 32'h0);
  endtask

  task automatic test_starve();
    int exp_id[5];
    int got[$];
    int gcyc[$];
    int loss = 0, cyc = 0;
    for (int k = 0; k < 5; k++) begin
      exp_id[k] = (LIM != 0 && loss == LIM) ? 0 : 1;
      loss = exp_id[k] == 0 ? 0 : loss + 1;
    end
    @(negedge clk);
    ls_wr = 0; ls_addr = 32'h80; if_addr = 32'h200; ls_req = 1; if_req = 1;
    while (got.size() < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (if_gnt) begin got.push_back(0); gcyc.push_back(cyc); if_req = 0; end
      if (ls_gnt) begin got.push_back(1); gcyc.push_back(cyc); end
    end
    ls_req = 0;
    if_req = 0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (k >= got.size() || got[k] != exp_id[k]) begin
        n_fail++;
        $display("FAIL starve_order grant=%0d got %0d want %0d (1=LS)", k, k < got.size() ? got[k] : -1, exp_id[k]);
      end else if (k > 0 && gcyc[k] - gcyc[k-1] != LAT_A + 1) begin
        n_fail++;
        $display("FAIL starve_spacing grant=%0d got %0d want %0d", k, gcyc[k] - gcyc[k-1], LAT_A + 1);
      end
    end
  endtask

  task automatic test_lat3();
    logic [31:0] addrs[3];
    int vcyc[3];
    int gi = 0, vi = 0, cyc = 0, ce_n = 0, g0 = -1;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    @(negedge clk);
    b_ls_wr = 0; b_ls_addr = addrs[0]; b_ls_req = 1;
    while (vi < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (b_ls_gnt) begin
        gi++;
        if (gi == 1) g0 = cyc;
        if (gi < 3) b_ls_addr = addrs[gi];
        else b_ls_req = 0;
      end
      if (b_ram_ce) begin
        ce_n++; n_chk++;
        if ({b_ram_rd, b_ram_wr, b_ram_addr} !== {2'b10, addrs[gi == 0 ? 0 : gi - 1]}) begin
          n_fail++;
          $display("FAIL lat3_cmd got rd/wr=%b%b addr=%h want 10 %h", b_ram_rd, b_ram_wr, b_ram_addr, addrs[gi == 0 ? 0 : gi - 1]);
        end
      end
      if (b_ls_valid) begin
        vcyc[vi] = cyc; n_chk++;
        if (b_ls_rdata !== model_rd(addrs[vi])) begin
          n_fail++;
          $display("FAIL lat3_data n=%0d got %h want %h", vi, b_ls_rdata, model_rd(addrs[vi]));
        end
        vi++;
      end
    end
    b_ls_req = 0;
    n_chk++;
    if (vi != 3 || ce_n != 9 || vcyc[0] != g0 + LAT_B || vcyc[1] - vcyc[0] != LAT_B + 1 || vcyc[2] - vcyc[1] != LAT_B + 1) begin
      n_fail++;
      $display("FAIL lat3_timing got valids=%0d ce_cycles=%0d gnt0=%0d v=%0d,%0d,%0d want 3 9 v0=gnt0+%0d step %0d",
               vi, ce_n, g0, vcyc[0], vcyc[1], vcyc[2], LAT_B, LAT_B + 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int s;
      bit lw;
      logic [31:0] ia, la;
      s  = $urandom_range(1, 3);
      lw = 1'($urandom_range(0, 1));
      ia = 32'h400 + 32'(4 * $urandom_range(0, 7));
      la = 32'h400 + 32'(4 * $urandom_range(0, 7));
      txn(s[0], s[1], ia, la, lw, $urandom);
    end
  endtask

  task automatic test_perf();
    logic [31:0] e_if, e_ls, e_st;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    txn(1, 0, 32'h300, 32'h0, 0, 32'h0);
    txn(1, 0, 32'h304, 32'h0, 0, 32'h0);
    txn(0, 1, 32'h0, 32'h308, 0, 32'h0);
    txn(1, 1, 32'h30C, 32'h310, 1, 32'hCAFE_F00D);
`ifdef MEM_ARB_PERF_EN
    e_if = 3; e_ls = 2; e_st = LAT_A;
`else
    e_if = 0; e_ls = 0; e_st = 0;
`endif
    @(negedge clk);
    n_chk++;
    if (perf_if !== e_if) begin n_fail++; $display("FAIL perf_if got %0d want %0d", perf_if, e_if); end
    n_chk++;
    if (perf_ls !== e_ls) begin n_fail++; $display("FAIL perf_ls got %0d want %0d", perf_ls, e_ls); end
    n_chk++;
    if (perf_st !== e_st) begin n_fail++; $display("FAIL perf_stall got %0d want %0d", perf_st, e_st); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_if_read();
    test_collision();
    test_starve();
    test_lat3();
    test_random();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
